// File: rtl/peripheral_apb4_slave_regfile.sv
// APB4 completer with a bank of software-writable control words and read-only status words.
// Supports programmable wait states, byte strobes, PSLVERR on bad accesses and a sticky protocol-error flag.
module peripheral_apb4_slave_regfile #(
    parameter int PADDR_SIZE  = 16,
    parameter int PDATA_SIZE  = 32,
    parameter int NUM_REGS    = 8,
    parameter int RW_REGS     = 4,
    parameter int WAIT_STATES = 0
) (
    input  logic                                     PCLK,
    input  logic                                     PRESETn,
    input  logic                                     PSEL,
    input  logic                                     PENABLE,
    input  logic [PADDR_SIZE-1:0]                    PADDR,
    input  logic [PDATA_SIZE/8-1:0]                  PSTRB,
    input  logic [PDATA_SIZE-1:0]                    PWDATA,
    input  logic                                     PWRITE,
    output logic [PDATA_SIZE-1:0]                    PRDATA,
    output logic                                     PREADY,
    output logic                                     PSLVERR,
    output logic [RW_REGS*PDATA_SIZE-1:0]            ctrl_o,
    input  logic [(NUM_REGS-RW_REGS)*PDATA_SIZE-1:0] status_i,
    output logic [RW_REGS-1:0]                       wr_pulse_o,
    output logic                                     proto_err_o
);

    localparam int                    BYTES      = PDATA_SIZE / 8;
    localparam int                    LSB        = $clog2(BYTES);
    localparam int                    IDXW       = $clog2(NUM_REGS);
    localparam logic [PADDR_SIZE-1:0] ADDR_LIMIT = PADDR_SIZE'(NUM_REGS * BYTES);
    localparam logic [PADDR_SIZE-1:0] ALIGN_MASK = PADDR_SIZE'(BYTES - 1);
    localparam logic [3:0]            WAIT_INIT  = 4'(WAIT_STATES);

    // The setup phase is recognised while in IDLE (address captured there), so ACCESS
    // coincides with the first PENABLE cycle and zero-wait transfers finish in it.
    typedef enum logic {ST_IDLE, ST_ACCESS} state_t;

    state_t                  r_state;
    state_t                  w_next;
    logic [3:0]              r_cnt;
    logic [PADDR_SIZE-1:0]   r_addr;
    logic                    r_write;
    logic [PDATA_SIZE-1:0]   r_ctrl [RW_REGS];
    logic [PDATA_SIZE-1:0]   w_words [NUM_REGS];
    logic [RW_REGS-1:0]      r_wr_pulse;
    logic                    r_proto_err;
    logic                    w_setup;
    logic                    w_bus_access;
    logic                    w_ready;
    logic                    w_bad_addr;
    logic                    w_err;
    logic                    w_commit;
    logic                    w_proto_viol;
    logic [IDXW-1:0]         w_idx;

    assign w_setup      = PSEL & ~PENABLE;
    assign w_bus_access = PSEL & PENABLE;
    assign w_idx        = r_addr[LSB +: IDXW];
    assign w_bad_addr   = (r_addr >= ADDR_LIMIT) || ((r_addr & ALIGN_MASK) != '0);
    assign w_err        = w_bad_addr || (r_write && (int'(w_idx) >= RW_REGS));
    assign w_ready      = (r_state == ST_ACCESS) && (r_cnt == '0);
    assign w_commit     = w_ready && w_bus_access && r_write && !w_err;
    assign w_proto_viol = (r_state == ST_IDLE) ? w_bus_access : !w_bus_access;

    for (genvar g = 0; g < NUM_REGS; g++) begin : g_words
        if (g < RW_REGS) begin : g_rw
            assign w_words[g]                             = r_ctrl[g];
            assign ctrl_o[g*PDATA_SIZE +: PDATA_SIZE]     = r_ctrl[g];
        end else begin : g_ro
            assign w_words[g] = status_i[(g-RW_REGS)*PDATA_SIZE +: PDATA_SIZE];
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge PCLK) begin
        if (!PRESETn) r_state <= ST_IDLE;
        else          r_state <= w_next;
    end

    // NOTE: w_next gets a default before the case, so no path can infer a latch.
    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE:   if (w_setup) w_next = ST_ACCESS;
            ST_ACCESS: if (!w_bus_access || (r_cnt == '0)) w_next = ST_IDLE;
            default:   w_next = ST_IDLE;
        endcase
    end

    always_comb begin
        PREADY  = w_ready;
        PSLVERR = w_ready && w_err;
        PRDATA  = '0;
        if (w_ready && !r_write && !w_err) PRDATA = w_words[w_idx];
    end

    always_ff @(posedge PCLK) begin
        if (!PRESETn) begin
            r_cnt       <= '0;
            r_addr      <= '0;
            r_write     <= 1'b0;
            r_wr_pulse  <= '0;
            r_proto_err <= 1'b0;
            // NOTE: the register bank is reset because its contents drive ctrl_o directly.
            for (int i = 0; i < RW_REGS; i++) r_ctrl[i] <= '0;
        end else begin
            if ((r_state == ST_IDLE) && w_setup) begin
                r_cnt   <= WAIT_INIT;
                r_addr  <= PADDR;
                r_write <= PWRITE;
            end else if ((r_state == ST_ACCESS) && (r_cnt != '0)) begin
                r_cnt <= r_cnt - 1'b1;
            end
            if (w_proto_viol) r_proto_err <= 1'b1;
            for (int i = 0; i < RW_REGS; i++) begin
                r_wr_pulse[i] <= w_commit && (int'(w_idx) == i);
                for (int b = 0; b < BYTES; b++) begin
                    if (w_commit && (int'(w_idx) == i) && PSTRB[b])
                        r_ctrl[i][b*8 +: 8] <= PWDATA[b*8 +: 8];
                end
            end
        end
    end

    assign wr_pulse_o  = r_wr_pulse;
    assign proto_err_o = r_proto_err;

endmodule

// File: tb/tb_peripheral_apb4_slave_regfile.sv
// Directed bench for peripheral_apb4_slave_regfile: a zero-wait and a three-wait instance share
// one APB bus (separate PSEL); expected responses are queued at setup and popped at PREADY.
module tb_peripheral_apb4_slave_regfile;

    localparam int AW = 16;
    localparam int DW = 32;
    localparam int NR = 8;
    localparam int RW = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                  presetn;
    logic                  psel0, psel3, penable, pwrite;
    logic [AW-1:0]         paddr;
    logic [DW/8-1:0]       pstrb;
    logic [DW-1:0]         pwdata;
    logic [(NR-RW)*DW-1:0] status;

    logic [DW-1:0]         prdata0, prdata3;
    logic                  pready0, pready3, pslverr0, pslverr3, perr0, perr3;
    logic [RW*DW-1:0]      ctrl0, ctrl3;
    logic [RW-1:0]         pulse0, pulse3;

    peripheral_apb4_slave_regfile #(
        .PADDR_SIZE(AW), .PDATA_SIZE(DW), .NUM_REGS(NR), .RW_REGS(RW), .WAIT_STATES(0)
    ) dut0 (
        .PCLK(clk), .PRESETn(presetn), .PSEL(psel0), .PENABLE(penable), .PADDR(paddr),
        .PSTRB(pstrb), .PWDATA(pwdata), .PWRITE(pwrite), .PRDATA(prdata0), .PREADY(pready0),
        .PSLVERR(pslverr0), .ctrl_o(ctrl0), .status_i(status), .wr_pulse_o(pulse0),
        .proto_err_o(perr0)
    );

    peripheral_apb4_slave_regfile #(
        .PADDR_SIZE(AW), .PDATA_SIZE(DW), .NUM_REGS(NR), .RW_REGS(RW), .WAIT_STATES(3)
    ) dut3 (
        .PCLK(clk), .PRESETn(presetn), .PSEL(psel3), .PENABLE(penable), .PADDR(paddr),
        .PSTRB(pstrb), .PWDATA(pwdata), .PWRITE(pwrite), .PRDATA(prdata3), .PREADY(pready3),
        .PSLVERR(pslverr3), .ctrl_o(ctrl3), .status_i(status), .wr_pulse_o(pulse3),
        .proto_err_o(perr3)
    );

    typedef struct {
        logic [DW-1:0] rdata;
        logic          err;
        int            waits;
        logic [RW-1:0] pulse;
    } exp_t;

    exp_t sb[$];
    int   n_vec  = 0;
    int   n_fail = 0;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic xfer(input int which, input logic [AW-1:0] addr, input logic wr,
                        input logic [DW/8-1:0] strb, input logic [DW-1:0] wdata,
                        input logic [DW-1:0] exp_rdata, input logic exp_err, input int exp_waits,
                        input logic [RW-1:0] exp_pulse, input string tag);
        exp_t e;
        int   waits;
        logic rdy;
        e.rdata = exp_rdata;
        e.err   = exp_err;
        e.waits = exp_waits;
        e.pulse = exp_pulse;
        sb.push_back(e);
        @(negedge clk);
        if (which == 0) psel0 = 1'b1; else psel3 = 1'b1;
        penable = 1'b0;
        paddr   = addr;
        pwrite  = wr;
        pstrb   = strb;
        pwdata  = wdata;
        @(negedge clk);
        penable = 1'b1;
        waits   = 0;
        rdy     = 1'b0;
        for (int c = 0; c < 40; c++) begin
            #1;
            rdy = (which == 0) ? pready0 : pready3;
            if (rdy) break;
            waits++;
            @(negedge clk);
        end
        e = sb.pop_front();
        check({tag, "_pready"}, 128'(rdy), 128'(1));
        if (rdy) begin
            check({tag, "_waits"}, 128'(waits), 128'(e.waits));
            check({tag, "_prdata"}, (which == 0) ? prdata0 : prdata3, e.rdata);
            check({tag, "_pslverr"}, (which == 0) ? pslverr0 : pslverr3, e.err);
        end
        @(negedge clk);
        psel0   = 1'b0;
        psel3   = 1'b0;
        penable = 1'b0;
        #1;
        check({tag, "_pulse"}, (which == 0) ? pulse0 : pulse3, e.pulse);
        @(negedge clk);
        #1;
        check({tag, "_pulse_clr"}, (which == 0) ? pulse0 : pulse3, 128'(0));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        presetn = 1'b0;
        psel0   = 1'b0;
        psel3   = 1'b0;
        penable = 1'b0;
        pwrite  = 1'b0;
        paddr   = '0;
        pstrb   = '0;
        pwdata  = '0;
        status  = {32'h0BADF00D, 32'h77778888, 32'h13579BDF, 32'hA5A5A5A5};

        // Reset state
        repeat (3) @(negedge clk);
        #1;
        check("rst_pready", pready0, 0);
        check("rst_pslverr", pslverr0, 0);
        check("rst_prdata", prdata0, 0);
        check("rst_ctrl", ctrl0, 0);
        check("rst_pulse", pulse0, 0);
        check("rst_proto", perr0, 0);
        @(negedge clk);
        presetn = 1'b1;

        // Zero-wait write/read, strobes, empty-strobe pulse
        xfer(0, 16'h0000, 1, 4'hF, 32'hDEADBEEF, 32'h0, 0, 0, 4'b0001, "t1_wr0");
        check("t1_ctrl0", ctrl0[31:0], 32'hDEADBEEF);
        xfer(0, 16'h0000, 0, 4'h0, 32'h0, 32'hDEADBEEF, 0, 0, 4'b0000, "t1_rd0");
        xfer(0, 16'h0000, 1, 4'h2, 32'h11223344, 32'h0, 0, 0, 4'b0001, "t2_strb");
        check("t2_ctrl0", ctrl0[31:0], 32'hDEAD33EF);
        xfer(0, 16'h0004, 1, 4'hF, 32'h12345678, 32'h0, 0, 0, 4'b0010, "t2_wr1");
        xfer(0, 16'h0004, 1, 4'h0, 32'hFFFFFFFF, 32'h0, 0, 0, 4'b0010, "t2_nostrb");
        check("t2_ctrl1", ctrl0[63:32], 32'h12345678);
        xfer(0, 16'h000C, 1, 4'h9, 32'hAABBCCDD, 32'h0, 0, 0, 4'b1000, "t2_wr3");
        xfer(0, 16'h000C, 0, 4'h0, 32'h0, 32'hAA0000DD, 0, 0, 4'b0000, "t2_rd3");
        xfer(0, 16'h0014, 0, 4'h0, 32'h0, 32'h13579BDF, 0, 0, 4'b0000, "t2_rdst1");
        xfer(0, 16'h001C, 0, 4'h0, 32'h0, 32'h0BADF00D, 0, 0, 4'b0000, "t2_rdst3");

        // Three wait states
        xfer(3, 16'h0010, 0, 4'h0, 32'h0, 32'hA5A5A5A5, 0, 3, 4'b0000, "t3_rdst0");
        xfer(3, 16'h0008, 1, 4'hF, 32'h55AA55AA, 32'h0, 0, 3, 4'b0100, "t3_wr2");
        check("t3_ctrl2", ctrl3[95:64], 32'h55AA55AA);

        // Erroring accesses
        xfer(0, 16'h0010, 1, 4'hF, 32'hFFFFFFFF, 32'h0, 1, 0, 4'b0000, "t4_wr_ro");
        xfer(0, 16'h0002, 1, 4'hF, 32'hFFFFFFFF, 32'h0, 1, 0, 4'b0000, "t4_wr_mis");
        xfer(0, 16'h0040, 0, 4'h0, 32'h0, 32'h0, 1, 0, 4'b0000, "t4_rd_oor");
        xfer(0, 16'h0020, 0, 4'h0, 32'h0, 32'h0, 1, 0, 4'b0000, "t4_rd_lim");
        xfer(0, 16'h0006, 0, 4'h0, 32'h0, 32'h0, 1, 0, 4'b0000, "t4_rd_mis");
        check("t4_ctrl", ctrl0, {32'hAA0000DD, 32'h0, 32'h12345678, 32'hDEAD33EF});

        // Access phase without setup
        @(negedge clk);
        psel0   = 1'b1;
        penable = 1'b1;
        paddr   = 16'h0000;
        pwrite  = 1'b0;
        #1;
        check("t5_no_pready", pready0, 0);
        @(negedge clk);
        psel0   = 1'b0;
        penable = 1'b0;
        #1;
        check("t5_proto_set", perr0, 1);
        xfer(0, 16'h0000, 0, 4'h0, 32'h0, 32'hDEAD33EF, 0, 0, 4'b0000, "t5_rd0");
        check("t5_proto_sticky", perr0, 1);
        check("t5_proto_other", perr3, 0);

        // Reset in the middle of a wait-state write
        @(negedge clk);
        psel3   = 1'b1;
        penable = 1'b0;
        paddr   = 16'h0000;
        pwrite  = 1'b1;
        pstrb   = 4'hF;
        pwdata  = 32'hCAFEF00D;
        @(negedge clk);
        penable = 1'b1;
        @(negedge clk);
        presetn = 1'b0;
        @(negedge clk);
        #1;
        check("t6_pready", pready3, 0);
        check("t6_ctrl3", ctrl3, 0);
        check("t6_pulse", pulse3, 0);
        check("t6_proto_clr", perr0, 0);
        psel3   = 1'b0;
        penable = 1'b0;
        presetn = 1'b1;
        repeat (4) @(negedge clk);
        #1;
        check("t6_ctrl3_after", ctrl3, 0);
        xfer(3, 16'h0004, 1, 4'hF, 32'h600DF00D, 32'h0, 0, 3, 4'b0010, "t6_wr1");
        xfer(3, 16'h0004, 0, 4'h0, 32'h0, 32'h600DF00D, 0, 3, 4'b0000, "t6_rd1");
        xfer(3, 16'h0000, 0, 4'h0, 32'h0, 32'h0, 0, 3, 4'b0000, "t6_rd0");
        check("t6_proto3", perr3, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
